phoneme_player: RTL and testbench
=================================

PHONEME_PLAYER -- requirements
Module: phoneme_player

Interface
REQ-001 SHALL have parameter ADDR_W, default 23: word-address width of the sample memory.
REQ-002 SHALL have parameter NUM_PHONEMES, default 64: number of valid phoneme codes (0..NUM_PHONEMES-1).
REQ-003 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port phoneme_selection  input  8: phoneme code written by the controller.
REQ-006 SHALL have port fsm_start_signal  input  1: level request from the controller; rising edge starts playback.
REQ-007 SHALL have port sample_tick  input  1: one-cycle audio-rate enable, e.g. 22 kHz.
REQ-008 SHALL have port mem_addr  output  ADDR_W: word address to the sample memory.
REQ-009 SHALL have port mem_read  output  1: read request, held until accepted.
REQ-010 SHALL have port mem_waitrequest  input  1: memory stall; read is accepted on a cycle with mem_read=1 and mem_waitrequest=0.
REQ-011 SHALL have port mem_readdatavalid  input  1: mem_readdata is valid this cycle.
REQ-012 SHALL have port mem_readdata  input  32: four 8-bit signed samples; byte 0 is played first.
REQ-013 SHALL have port audio_out  output  8: current sample, signed.
REQ-014 SHALL have port audio_valid  output  1: one-cycle pulse when audio_out updates.
REQ-015 SHALL have port fsm_finish_signal  output  1: playback complete; read by the controller.

Function
REQ-016 SHALL use states IDLE, LOOKUP, FETCH, WAIT_DATA, PLAY, DONE.
REQ-017 IDLE SHALL leave on a 0->1 transition of fsm_start_signal, registered one cycle, and SHALL latch phoneme_selection on that cycle.
REQ-018 LOOKUP SHALL load cur_addr=start_addr and end_addr from the table in one cycle; a code >= NUM_PHONEMES or start_addr > end_addr SHALL go directly to DONE.
REQ-019 FETCH SHALL drive mem_read=1 and mem_addr=cur_addr until accepted, then go to WAIT_DATA.
REQ-020 WAIT_DATA SHALL capture mem_readdata into a 32-bit word register on mem_readdatavalid, set byte_idx=0, and go to PLAY.
REQ-021 PLAY SHALL, on each sample_tick, drive audio_out=byte[byte_idx], pulse audio_valid on the next cycle, and increment byte_idx; a sample_tick on any other state SHALL be ignored.
REQ-022 After byte 3 is played: if cur_addr==end_addr, go to DONE; otherwise increment cur_addr and go to FETCH.
REQ-023 end_addr SHALL be inclusive; a one-word phoneme SHALL play exactly 4 samples.
REQ-024 DONE SHALL hold fsm_finish_signal=1 until fsm_start_signal=0, then return to IDLE; start held high SHALL NOT retrigger.
REQ-025 fsm_start_signal falling in LOOKUP..PLAY SHALL NOT abort playback.
REQ-026 audio_out SHALL hold its last value between ticks and after DONE.
REQ-027 cur_addr arithmetic SHALL be ADDR_W-bit modulo; wrap is prevented by REQ-018.
REQ-028 mem_readdatavalid outside WAIT_DATA SHALL be ignored.

Reset
REQ-029 Reset SHALL force IDLE, mem_read=0, mem_addr=0, audio_out=0, audio_valid=0, fsm_finish_signal=0, byte_idx=0, and clear the start edge register.
REQ-030 Reset during any state SHALL take effect next edge; an outstanding memory read SHALL be abandoned, and its late readdatavalid SHALL be ignored per REQ-028.
REQ-031 A start already high at reset release SHALL NOT start playback until it goes low and then high.

Structure
REQ-032 A shared package SHALL hold the state enum, ADDR_W default, and phoneme table width constants.
REQ-033 Sub-module phoneme_addr_table SHALL map the 8-bit code to {start_addr, end_addr} combinationally from a constant table.

Verification
REQ-034 Reset, then code 5 with table 5 = {0x100, 0x101} and start 0->1 -> reads at 0x100 and 0x101; 8 audio_valid pulses carrying bytes 0..3 of each word in order; finish=1.
REQ-035 Memory stalls mem_waitrequest for 3 cycles and mem_readdatavalid for 5 cycles -> mem_addr stable while stalled, no samples lost or duplicated.
REQ-036 Code 200 (>= NUM_PHONEMES) -> finish within 3 cycles, no mem_read, no audio_valid.
REQ-037 Start held high after finish -> finish stays 1, no replay; start low -> finish 0 and IDLE next cycle.
REQ-038 Reset asserted in PLAY with a read outstanding -> all outputs at reset values; a late readdatavalid is ignored; the next start plays correctly.
REQ-039 Back-to-back sample_tick on consecutive cycles -> one sample per tick with no skipped bytes.

Source files
------------

// File: rtl/phoneme_player_pkg.sv
// phoneme_player_pkg
// Shared definitions for the phoneme player slice.
//   state_t            : playback FSM states
//   ADDR_W_DEFAULT     : default word-address width of the sample memory
//   NUM_PHONEMES_DEFAULT : default count of valid phoneme codes
//   CODE_W             : phoneme code width
//   TABLE_ADDR_W       : width of one address stored in the phoneme table
//   TABLE_ENTRY_W      : width of one {start_addr, end_addr} table entry
//   sample_byte()      : selects one 8-bit sample out of a 32-bit memory word
package phoneme_player_pkg;

  localparam int ADDR_W_DEFAULT       = 23;
  localparam int NUM_PHONEMES_DEFAULT = 64;
  localparam int CODE_W               = 8;
  localparam int TABLE_ADDR_W         = 16;
  localparam int TABLE_ENTRY_W        = 2 * TABLE_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FETCH,
    WAIT_DATA,
    PLAY,
    DONE
  } state_t;

  // Byte 0 sits in the least significant bits and is played first.
  function automatic logic [7:0] sample_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/phoneme_player_addr_table.sv
// phoneme_addr_table
// Constant lookup from an 8-bit phoneme code to the inclusive word range
// holding that phoneme's samples.
//   code       : phoneme code
//   start_addr : first word address of the phoneme
//   end_addr   : last word address of the phoneme (inclusive)
module phoneme_addr_table
  import phoneme_player_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [CODE_W-1:0] code,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] end_addr
);

  logic [TABLE_ENTRY_W-1:0] entry;

  // Codes without an explicit entry map to a one-word phoneme at 0x40<code>.
  // Code 7 is deliberately stored with start > end, marking an empty phoneme.
  always_comb begin
    entry = {8'h40, code, 8'h40, code};
    case (code)
      8'd0:    entry = {16'h0000, 16'h0000};
      8'd1:    entry = {16'h0010, 16'h0012};
      8'd5:    entry = {16'h0100, 16'h0101};
      8'd7:    entry = {16'h0200, 16'h01FF};
      default: entry = {8'h40, code, 8'h40, code};
    endcase
  end

  assign start_addr = ADDR_W'(entry[TABLE_ENTRY_W-1 -: TABLE_ADDR_W]);
  assign end_addr   = ADDR_W'(entry[TABLE_ADDR_W-1:0]);

endmodule

// File: rtl/phoneme_player.sv
// phoneme_player
// Plays one phoneme: looks up its word range, reads each 32-bit word from
// the sample memory and emits its four signed bytes on successive audio ticks.
//   clk, reset            : clock and synchronous active-high reset
//   phoneme_selection     : phoneme code from the controller
//   fsm_start_signal      : level request, rising edge starts playback
//   sample_tick           : audio-rate enable
//   mem_addr, mem_read    : read request to sample memory (held until accepted)
//   mem_waitrequest       : memory stall
//   mem_readdatavalid, mem_readdata : read response
//   audio_out, audio_valid: current sample and its one-cycle update pulse
//   fsm_finish_signal     : playback complete, held until start drops
module phoneme_player
  import phoneme_player_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int NUM_PHONEMES = NUM_PHONEMES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        phoneme_selection,
  input  logic              fsm_start_signal,
  input  logic              sample_tick,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic              mem_readdatavalid,
  input  logic [31:0]       mem_readdata,
  output logic [7:0]        audio_out,
  output logic              audio_valid,
  output logic              fsm_finish_signal
);

  state_t            state;
  logic              start_q;
  logic              start_edge;
  logic [7:0]        code;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] tbl_start;
  logic [ADDR_W-1:0] tbl_end;
  logic [31:0]       word;
  logic [1:0]        byte_idx;
  logic              code_invalid;

  phoneme_addr_table #(.ADDR_W(ADDR_W)) u_table (
    .code       (code),
    .start_addr (tbl_start),
    .end_addr   (tbl_end)
  );

  assign code_invalid = ({24'd0, code} >= 32'(NUM_PHONEMES));

  // Registered rising-edge detect on the start request. Reset primes the
  // history bit high so a request already high at reset release must drop
  // and rise again before it counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q    <= 1'b1;
      start_edge <= 1'b0;
    end else begin
      start_q    <= fsm_start_signal;
      start_edge <= fsm_start_signal & ~start_q;
    end
  end

  // Playback FSM with all outputs registered. Memory responses and ticks
  // outside the states that expect them fall through untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      mem_read          <= 1'b0;
      mem_addr          <= '0;
      audio_out         <= '0;
      audio_valid       <= 1'b0;
      fsm_finish_signal <= 1'b0;
      byte_idx          <= '0;
      code              <= '0;
      cur_addr          <= '0;
      end_addr          <= '0;
      word              <= '0;
    end else begin
      audio_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            code  <= phoneme_selection;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          cur_addr <= tbl_start;
          end_addr <= tbl_end;
          if (code_invalid || (tbl_start > tbl_end)) begin
            fsm_finish_signal <= 1'b1;
            state             <= DONE;
          end else begin
            mem_addr <= tbl_start;
            mem_read <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            state    <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (mem_readdatavalid) begin
            word     <= mem_readdata;
            byte_idx <= '0;
            state    <= PLAY;
          end
        end
        PLAY: begin
          if (sample_tick) begin
            audio_out   <= sample_byte(word, byte_idx);
            audio_valid <= 1'b1;
            byte_idx    <= byte_idx + 2'd1;
            // end_addr is inclusive, so the range ends only after the
            // last byte of the word at end_addr has been played.
            if (byte_idx == 2'd3) begin
              if (cur_addr == end_addr) begin
                fsm_finish_signal <= 1'b1;
                state             <= DONE;
              end else begin
                cur_addr <= cur_addr + 1'b1;
                mem_addr <= cur_addr + 1'b1;
                mem_read <= 1'b1;
                state    <= FETCH;
              end
            end
          end
        end
        DONE: begin
          if (!fsm_start_signal) begin
            fsm_finish_signal <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phoneme_player.sv
// tb_phoneme_player
// Self-checking bench for phoneme_player: a behavioural memory with
// programmable stalls, random audio ticks, and a reference model that
// lists the expected word addresses and byte stream for each phoneme.
`timescale 1ns/1ps
module tb_phoneme_player;

  localparam int ADDR_W = 23;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        phoneme_selection;
  logic              fsm_start_signal;
  logic              sample_tick;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_waitrequest;
  logic              mem_readdatavalid;
  logic [31:0]       mem_readdata;
  logic [7:0]        audio_out;
  logic              audio_valid;
  logic              fsm_finish_signal;

  int compared   = 0;
  int mismatched = 0;

  // memory / tick behaviour knobs, changed only while the DUT is idle
  int wait_stall = 0;
  int dv_stall   = 0;
  bit tick_b2b   = 1'b0;

  int                wait_left = 0;
  int                dv_left   = 0;
  bit                in_req    = 1'b0;
  bit                pending   = 1'b0;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] pend_addr;
  int                addr_unstable = 0;

  logic [ADDR_W-1:0] got_addrs[$];
  logic [7:0]        got_samples[$];
  logic [ADDR_W-1:0] exp_addrs[$];
  logic [7:0]        exp_samples[$];

  always #5 clk = ~clk;

  phoneme_player #(.ADDR_W(ADDR_W), .NUM_PHONEMES(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .phoneme_selection (phoneme_selection),
    .fsm_start_signal  (fsm_start_signal),
    .sample_tick       (sample_tick),
    .mem_addr          (mem_addr),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_readdata      (mem_readdata),
    .audio_out         (audio_out),
    .audio_valid       (audio_valid),
    .fsm_finish_signal (fsm_finish_signal)
  );

  // contents of the sample memory: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] x;
    x = 32'(a);
    return (x * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  // phoneme table as documented for this design: {start, end}
  function automatic logic [31:0] ref_entry(input logic [7:0] c);
    case (c)
      8'd0:    return {16'h0000, 16'h0000};
      8'd1:    return {16'h0010, 16'h0012};
      8'd5:    return {16'h0100, 16'h0101};
      8'd7:    return {16'h0200, 16'h01FF};
      default: return {8'h40, c, 8'h40, c};
    endcase
  endfunction

  // expected reads and byte stream for one playback of code c
  task automatic buildExpected(input logic [7:0] c);
    logic [31:0] e;
    logic [31:0] w;
    int s;
    int en;
    exp_addrs.delete();
    exp_samples.delete();
    e  = ref_entry(c);
    s  = int'(e[31:16]);
    en = int'(e[15:0]);
    if (int'(c) >= 64 || s > en) return;
    for (int a = s; a <= en; a++) begin
      exp_addrs.push_back(ADDR_W'(a));
      w = mem_word(ADDR_W'(a));
      for (int b = 0; b < 4; b++) exp_samples.push_back(w[b*8 +: 8]);
    end
  endtask

  // memory responder, output monitor and tick source, all on the falling edge
  initial begin
    mem_waitrequest   = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata      = '0;
    sample_tick       = 1'b0;
    forever begin
      @(negedge clk);
      if (audio_valid) got_samples.push_back(audio_out);
      mem_readdatavalid = 1'b0;
      if (pending) begin
        if (dv_left > 0) dv_left--;
        else begin
          mem_readdatavalid = 1'b1;
          mem_readdata      = mem_word(pend_addr);
          pending           = 1'b0;
        end
      end
      mem_waitrequest = 1'b0;
      if (!mem_read) in_req = 1'b0;
      else begin
        if (!in_req) begin
          in_req    = 1'b1;
          req_addr  = mem_addr;
          wait_left = wait_stall;
        end else if (mem_addr !== req_addr) addr_unstable++;
        if (wait_left > 0) begin
          mem_waitrequest = 1'b1;
          wait_left--;
        end else begin
          got_addrs.push_back(mem_addr);
          pend_addr = mem_addr;
          pending   = 1'b1;
          dv_left   = dv_stall;
          in_req    = 1'b0;
        end
      end
      sample_tick = tick_b2b ? 1'b1 : ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] c);
    @(negedge clk);
    phoneme_selection = c;
    fsm_start_signal  = 1'b1;
  endtask

  task automatic clearCapture();
    got_addrs.delete();
    got_samples.delete();
  endtask

  task automatic waitFinish(input string tag);
    int n;
    n = 0;
    while (!fsm_finish_signal && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_finish"}, 64'(fsm_finish_signal), 64'd1);
    @(negedge clk);
  endtask

  task automatic checkPlayback(input string tag, input logic [7:0] c);
    buildExpected(c);
    checkOutput({tag, "_nreads"}, 64'(got_addrs.size()), 64'(exp_addrs.size()));
    for (int i = 0; i < exp_addrs.size() && i < got_addrs.size(); i++)
      checkOutput($sformatf("%s_addr%0d", tag, i), 64'(got_addrs[i]), 64'(exp_addrs[i]));
    checkOutput({tag, "_nsamples"}, 64'(got_samples.size()), 64'(exp_samples.size()));
    for (int i = 0; i < exp_samples.size() && i < got_samples.size(); i++)
      checkOutput($sformatf("%s_smp%0d", tag, i), 64'(got_samples[i]), 64'(exp_samples[i]));
    if (exp_samples.size() > 0)
      checkOutput({tag, "_hold"}, 64'(audio_out), 64'(exp_samples[$]));
  endtask

  task automatic releaseStart(input string tag);
    @(negedge clk);
    fsm_start_signal = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_release"}, 64'(fsm_finish_signal), 64'd0);
  endtask

  task automatic playOnce(input string tag, input logic [7:0] c);
    clearCapture();
    applyStimulus(c);
    waitFinish(tag);
    checkPlayback(tag, c);
    releaseStart(tag);
  endtask

  initial begin
    logic [7:0] rc;
    int n;
    reset             = 1'b1;
    fsm_start_signal  = 1'b0;
    phoneme_selection = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_audio_out", 64'(audio_out), 64'd0);
    checkOutput("rst_audio_valid", 64'(audio_valid), 64'd0);
    checkOutput("rst_mem_read", 64'(mem_read), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_finish", 64'(fsm_finish_signal), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // two-word phoneme, then start held high must not replay
    clearCapture();
    applyStimulus(8'd5);
    waitFinish("code5");
    checkPlayback("code5", 8'd5);
    repeat (10) @(negedge clk);
    checkOutput("hold_finish", 64'(fsm_finish_signal), 64'd1);
    checkOutput("hold_noreplay", 64'(got_addrs.size()), 64'd2);
    releaseStart("code5");

    // memory stalls on both request and response
    wait_stall = 3;
    dv_stall   = 5;
    addr_unstable = 0;
    playOnce("stall", 8'd1);
    checkOutput("stall_addr_stable", 64'(addr_unstable), 64'd0);
    wait_stall = 0;
    dv_stall   = 0;

    // out-of-range code: finish within 3 cycles, no traffic
    clearCapture();
    applyStimulus(8'd200);
    repeat (3) @(negedge clk);
    checkOutput("bad_finish3", 64'(fsm_finish_signal), 64'd1);
    repeat (5) @(negedge clk);
    checkOutput("bad_noreads", 64'(got_addrs.size()), 64'd0);
    checkOutput("bad_nosamples", 64'(got_samples.size()), 64'd0);
    releaseStart("bad");

    // empty range (start > end)
    playOnce("empty", 8'd7);

    // back-to-back ticks, one-word phoneme
    tick_b2b = 1'b1;
    playOnce("b2b_one", 8'd0);
    playOnce("b2b_two", 8'd5);
    tick_b2b = 1'b0;

    // randomized codes, stalls and tick density
    for (int k = 0; k < 6; k++) begin
      rc         = 8'($urandom_range(0, 255));
      wait_stall = $urandom_range(0, 4);
      dv_stall   = $urandom_range(0, 4);
      tick_b2b   = ($urandom_range(0, 1) == 1);
      playOnce($sformatf("rnd%0d_c%0d", k, rc), rc);
    end
    wait_stall = 0;
    tick_b2b   = 1'b0;

    // reset mid-playback with a read outstanding
    dv_stall = 8;
    clearCapture();
    applyStimulus(8'd1);
    n = 0;
    while (got_addrs.size() < 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_second_read", 64'(got_addrs.size()), 64'd2);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midrst_audio_out", 64'(audio_out), 64'd0);
    checkOutput("midrst_audio_valid", 64'(audio_valid), 64'd0);
    checkOutput("midrst_mem_read", 64'(mem_read), 64'd0);
    checkOutput("midrst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("midrst_finish", 64'(fsm_finish_signal), 64'd0);
    reset = 1'b0;
    clearCapture();
    repeat (15) @(negedge clk);
    checkOutput("midrst_late_ignored", 64'(got_samples.size()), 64'd0);
    checkOutput("midrst_no_autostart", 64'(got_addrs.size()), 64'd0);
    checkOutput("midrst_idle_finish", 64'(fsm_finish_signal), 64'd0);
    dv_stall = 0;
    fsm_start_signal = 1'b0;
    repeat (2) @(negedge clk);
    playOnce("after_rst", 8'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
